uart_frame_decoder: RTL and testbench
=====================================

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 100000, the maximum inter-byte gap in clocks before a frame is aborted.
REQ-003 SHALL have port i_Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_Rx_DV, input, 1 bit: one-cycle pulse, received byte valid (from the UART receiver).
REQ-006 SHALL have port i_Rx_Byte, input, 8 bits: received byte, sampled only when i_Rx_DV=1.
REQ-007 SHALL have port o_Wr_Valid, output, 1 bit: memory write request.
REQ-008 SHALL have port i_Wr_Ready, input, 1 bit: memory accepts the write when o_Wr_Valid=1 and i_Wr_Ready=1.
REQ-009 SHALL have port o_Wr_Addr, output, 32 bits: byte address of the write.
REQ-010 SHALL have port o_Wr_Data, output, 8 bits: write data.
REQ-011 SHALL have port o_Jump_Valid, output, 1 bit: one-cycle pulse, jump command accepted.
REQ-012 SHALL have port o_Jump_Addr, output, 32 bits: jump target, valid while o_Jump_Valid=1.
REQ-013 SHALL have port o_Frame_Done, output, 1 bit: one-cycle pulse, frame completed with a good checksum.
REQ-014 SHALL have port o_Frame_Err, output, 1 bit: one-cycle pulse, frame rejected.
REQ-015 SHALL have port o_Busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL use frame format SYNC, CMD, ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24], LEN, then LEN payload bytes (0-255), then CHK.
REQ-017 SHALL use states IDLE, CMD, ADDR, LEN, PAYLOAD, CHECK; each state advances only on a cycle where i_Rx_DV=1.
REQ-018 SHALL, in IDLE, move to CMD on SYNC_BYTE and discard any other byte silently.
REQ-019 SHALL, in CMD, accept 8'h01 (WRITE) and 8'h02 (JUMP); any other CMD pulses o_Frame_Err one cycle later and returns to IDLE.
REQ-020 SHALL, in ADDR, collect 4 bytes little-endian using a 2-bit counter, then go to LEN.
REQ-021 SHALL, in LEN, go to PAYLOAD if CMD=WRITE and LEN!=0, otherwise go to CHECK.
REQ-022 SHALL flag a JUMP with LEN!=0 as an error at the CHECK stage.
REQ-023 SHALL keep an 8-bit running sum (mod 256) of CMD, the ADDR bytes, LEN, the payload bytes and CHK, cleared on entry to CMD.
REQ-024 SHALL treat the frame as good only if that sum is 8'h00, no error flag is set, and the checksum step below is reached.
REQ-025 SHALL, for payload byte k (0-based) arriving with i_Rx_DV in cycle N, assert o_Wr_Valid in cycle N+1 with o_Wr_Addr=ADDR+k (32-bit wrap) and o_Wr_Data=byte.
REQ-026 SHALL hold o_Wr_Valid, o_Wr_Addr and o_Wr_Data stable until i_Wr_Ready=1, then deassert o_Wr_Valid on the next edge unless a new byte loads in that same cycle.
REQ-027 SHALL, if a payload byte arrives while a write is pending and not accepted in that cycle, discard the byte, still count it toward LEN and checksum, and set a sticky overrun flag.
REQ-028 SHALL, one cycle after CHK is received, pulse exactly one of o_Frame_Done or o_Frame_Err (error if bad sum, overrun, or JUMP with LEN!=0), then return to IDLE.
REQ-029 SHALL, for a good JUMP, pulse o_Jump_Valid in the same cycle as o_Frame_Done, with o_Jump_Addr=ADDR.
REQ-030 SHALL, for a WRITE, issue writes before checksum validation; a bad checksum does not roll back writes.
REQ-031 SHALL keep a gap counter, reset to 0 on each i_Rx_DV; if outside IDLE and the counter reaches TIMEOUT_CLKS-1, pulse o_Frame_Err and go to IDLE.
REQ-032 SHALL let a pending write complete normally after a timeout or error.
REQ-033 SHALL be ready for the next SYNC in IDLE on the cycle after returning to IDLE.

Reset
REQ-034 SHALL, on i_Reset=1, immediately force state IDLE, all counters, sum and flags 0, and all outputs 0 (o_Wr_Valid, o_Jump_Valid, o_Frame_Done, o_Frame_Err, o_Busy=0; buses 0).
REQ-035 SHALL, when reset is applied mid-frame, abandon the frame with no error pulse and drop any pending write.

Verification
REQ-036 SHALL verify: A5 01 00 10 00 00 02 11 22 BA with i_Wr_Ready=1 -> writes (0x1000,0x11), (0x1001,0x22); o_Frame_Done pulse; no error.
REQ-037 SHALL verify: A5 02 00 00 00 80 00 7E -> o_Jump_Valid and o_Frame_Done in the same cycle, o_Jump_Addr=0x80000000.
REQ-038 SHALL verify: the frame of REQ-036 with CHK=BB -> both writes issued, then o_Frame_Err pulse, no o_Frame_Done.
REQ-039 SHALL verify: i_Wr_Ready=0 held across both payload bytes -> first write held stable, second byte dropped, o_Frame_Err at frame end.
REQ-040 SHALL verify: a frame stopped after its 3rd byte with TIMEOUT_CLKS=16 -> o_Frame_Err 16 clocks after the last i_Rx_DV, o_Busy=0; then a full valid frame succeeds.
REQ-041 SHALL verify: bytes 00 FF then A5 03 -> stray bytes ignored, then o_Frame_Err for the bad CMD; i_Reset asserted mid-payload -> all outputs 0 at once.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC/CMD/ADDR/LEN/payload/CHK frames from a UART byte stream into
// memory write requests and jump commands, with an additive checksum and an inter-byte timeout.
module uart_frame_decoder #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 100000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Wr_Valid,
    input  logic        i_Wr_Ready,
    output logic [31:0] o_Wr_Addr,
    output logic [7:0]  o_Wr_Data,
    output logic        o_Jump_Valid,
    output logic [31:0] o_Jump_Addr,
    output logic        o_Frame_Done,
    output logic        o_Frame_Err,
    output logic        o_Busy
);

    localparam logic [7:0]  CMD_WRITE = 8'h01;
    localparam logic [7:0]  CMD_JUMP  = 8'h02;
    // The gap counter reaches TIMEOUT_CLKS-1 on the same edge that aborts the frame.
    localparam logic [31:0] GAP_LIMIT = 32'(TIMEOUT_CLKS - 32'd2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CHECK   = 3'd5
    } state_t;

    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t      state_r, state_next_s;
    logic [7:0]  sum_r, sum_next_s;
    logic [31:0] addr_r;
    logic [7:0]  len_r;
    logic [7:0]  pay_cnt_r;
    logic [1:0]  addr_cnt_r;
    logic        jump_r;
    logic        overrun_r;
    logic [31:0] gap_r;
    logic        timeout_s, load_s, done_s, err_s, jump_s;
    logic        wr_valid_r, jump_valid_r, done_r, err_r, busy_r;
    logic [31:0] wr_addr_r, jump_addr_r;
    logic [7:0]  wr_data_r;

    // Next-state decode and frame verdict.
    always_comb begin
        state_next_s = state_r;
        done_s       = 1'b0;
        err_s        = 1'b0;
        jump_s       = 1'b0;
        sum_next_s   = sum8(sum_r, i_Rx_Byte);
        timeout_s    = (state_r != ST_IDLE) && !i_Rx_DV && (gap_r == GAP_LIMIT);
        load_s       = i_Rx_DV && (state_r == ST_PAYLOAD) && (!wr_valid_r || i_Wr_Ready);
        if (timeout_s) begin
            state_next_s = ST_IDLE;
            err_s        = 1'b1;
        end else if (i_Rx_DV) begin
            case (state_r)
                ST_IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) state_next_s = ST_CMD;
                    else                        state_next_s = ST_IDLE;
                end
                ST_CMD: begin
                    if ((i_Rx_Byte == CMD_WRITE) || (i_Rx_Byte == CMD_JUMP)) begin
                        state_next_s = ST_ADDR;
                    end else begin
                        state_next_s = ST_IDLE;
                        err_s        = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (addr_cnt_r == 2'd3) state_next_s = ST_LEN;
                    else                    state_next_s = ST_ADDR;
                end
                ST_LEN: begin
                    if (!jump_r && (i_Rx_Byte != 8'd0)) state_next_s = ST_PAYLOAD;
                    else                                state_next_s = ST_CHECK;
                end
                ST_PAYLOAD: begin
                    if (pay_cnt_r == (len_r - 8'd1)) state_next_s = ST_CHECK;
                    else                             state_next_s = ST_PAYLOAD;
                end
                ST_CHECK: begin
                    state_next_s = ST_IDLE;
                    if ((sum_next_s == 8'd0) && !overrun_r && !(jump_r && (len_r != 8'd0))) begin
                        done_s = 1'b1;
                        jump_s = jump_r;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state_r <= ST_IDLE;
        else         state_r <= state_next_s;
    end

    // Frame fields, running checksum and overrun flag.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sum_r      <= 8'd0;
            addr_r     <= 32'd0;
            len_r      <= 8'd0;
            pay_cnt_r  <= 8'd0;
            addr_cnt_r <= 2'd0;
            jump_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else if (i_Rx_DV) begin
            case (state_r)
                ST_IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        sum_r      <= 8'd0;
                        pay_cnt_r  <= 8'd0;
                        addr_cnt_r <= 2'd0;
                        overrun_r  <= 1'b0;
                    end
                end
                ST_CMD: begin
                    sum_r  <= sum_next_s;
                    jump_r <= (i_Rx_Byte == CMD_JUMP);
                end
                ST_ADDR: begin
                    sum_r      <= sum_next_s;
                    addr_r     <= {i_Rx_Byte, addr_r[31:8]};
                    addr_cnt_r <= addr_cnt_r + 2'd1;
                end
                ST_LEN: begin
                    sum_r <= sum_next_s;
                    len_r <= i_Rx_Byte;
                end
                ST_PAYLOAD: begin
                    sum_r     <= sum_next_s;
                    pay_cnt_r <= pay_cnt_r + 8'd1;
                    if (!load_s) overrun_r <= 1'b1;
                end
                ST_CHECK: sum_r <= sum_next_s;
                default:  sum_r <= sum_r;
            endcase
        end
    end

    // Inter-byte gap counter; only meaningful outside IDLE.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)                             gap_r <= 32'd0;
        else if (i_Rx_DV || (state_r == ST_IDLE)) gap_r <= 32'd0;
        else                                     gap_r <= gap_r + 32'd1;
    end

    // Registered outputs; a pending write survives frame aborts but not reset.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_valid_r   <= 1'b0;
            wr_addr_r    <= 32'd0;
            wr_data_r    <= 8'd0;
            jump_valid_r <= 1'b0;
            jump_addr_r  <= 32'd0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            done_r       <= done_s;
            err_r        <= err_s;
            jump_valid_r <= jump_s;
            busy_r       <= (state_next_s != ST_IDLE);
            if (jump_s) jump_addr_r <= addr_r;
            if (load_s) begin
                wr_valid_r <= 1'b1;
                wr_addr_r  <= addr_r + {24'd0, pay_cnt_r};
                wr_data_r  <= i_Rx_Byte;
            end else if (wr_valid_r && i_Wr_Ready) begin
                wr_valid_r <= 1'b0;
            end
        end
    end

    assign o_Wr_Valid   = wr_valid_r;
    assign o_Wr_Addr    = wr_addr_r;
    assign o_Wr_Data    = wr_data_r;
    assign o_Jump_Valid = jump_valid_r;
    assign o_Jump_Addr  = jump_addr_r;
    assign o_Frame_Done = done_r;
    assign o_Frame_Err  = err_r;
    assign o_Busy       = busy_r;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed and randomized frames for uart_frame_decoder, checked against a
// frame-level reference model (expected writes, verdict and jump target).
module tb_uart_frame_decoder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst, dv, wr_ready;
    logic [7:0]  rx_byte;
    logic        wr_valid, jump_valid, frame_done, frame_err, busy;
    logic [31:0] wr_addr, jump_addr;
    logic [7:0]  wr_data;

    always #5 clk = ~clk;

    uart_frame_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx_byte),
        .o_Wr_Valid(wr_valid), .i_Wr_Ready(wr_ready), .o_Wr_Addr(wr_addr),
        .o_Wr_Data(wr_data), .o_Jump_Valid(jump_valid), .o_Jump_Addr(jump_addr),
        .o_Frame_Done(frame_done), .o_Frame_Err(frame_err), .o_Busy(busy)
    );

    int total = 0, bad = 0;
    int cyc = 0, last_dv_cyc = -1, err_cyc = -1;
    int done_cnt = 0, err_cnt = 0, jump_cnt = 0, jump_done_cnt = 0, hold_viol = 0;
    logic [31:0] jump_addr_seen = 32'd0;
    logic [39:0] wr_q[$];
    logic [39:0] exp_q[$];
    logic [7:0]  fq[$];
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pa = 32'd0;
    logic [7:0]  pd = 8'd0;

    // Observe outputs once per cycle, mid-way between rising edges.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (dv) last_dv_cyc = cyc;
            if (pv && !pr && !(wr_valid && wr_addr == pa && wr_data == pd)) hold_viol++;
            if (wr_valid && wr_ready) wr_q.push_back({wr_addr, wr_data});
            if (frame_done) done_cnt++;
            if (frame_err) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (jump_valid) begin
                jump_cnt++;
                jump_addr_seen = jump_addr;
                if (frame_done) jump_done_cnt++;
            end
            pv = wr_valid; pr = wr_ready; pa = wr_addr; pd = wr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        done_cnt = 0; err_cnt = 0; jump_cnt = 0; jump_done_cnt = 0;
        hold_viol = 0; err_cyc = -1;
        wr_q.delete();
        exp_q.delete();
    endtask

    // Must be called at a falling edge; returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_fq(input int gapmax);
        foreach (fq[i]) send_byte(fq[i], $urandom_range(0, gapmax));
    endtask

    task automatic check_frame(input string tag, input int e_done, input int e_err,
                               input int e_jump, input logic [31:0] e_jaddr);
        repeat (4) @(negedge clk);
        chk({tag, "/done"}, done_cnt, e_done);
        chk({tag, "/err"}, err_cnt, e_err);
        chk({tag, "/jump"}, jump_cnt, e_jump);
        chk({tag, "/jump_with_done"}, jump_done_cnt, e_jump);
        if (e_jump > 0) chk({tag, "/jump_addr"}, jump_addr_seen, e_jaddr);
        chk({tag, "/nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            chk({tag, "/write"}, wr_q[i], exp_q[i]);
        chk({tag, "/hold"}, hold_viol, 0);
        chk({tag, "/busy_end"}, busy, 1'b0);
    endtask

    int          kind, len, s;
    logic [7:0]  cmd, ck, pb;
    logic [31:0] a;
    bit          corrupt, good;

    initial begin
        rst = 1'b1; dv = 1'b0; rx_byte = 8'd0; wr_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_outputs", {wr_valid, wr_addr, wr_data, jump_valid, jump_addr, frame_done, frame_err, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two-byte write, good checksum.
        clear_mon();
        fq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'hBA};
        exp_q = '{{32'h0000_1000, 8'h11}, {32'h0000_1001, 8'h22}};
        send_fq(2);
        check_frame("write_ok", 1, 0, 0, 32'd0);

        // Jump to 0x80000000.
        clear_mon();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h7E};
        send_fq(1);
        check_frame("jump_ok", 1, 0, 1, 32'h8000_0000);

        // Bad checksum: writes still issued.
        clear_mon();
        fq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'hBB};
        exp_q = '{{32'h0000_1000, 8'h11}, {32'h0000_1001, 8'h22}};
        send_fq(1);
        check_frame("bad_chk", 0, 1, 0, 32'd0);

        // Memory stalled: first write held, second byte dropped, overrun error.
        clear_mon();
        wr_ready = 1'b0;
        fq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'hBA};
        send_fq(1);
        repeat (3) @(negedge clk);
        chk("stall/valid_held", wr_valid, 1'b1);
        chk("stall/addr_held", wr_addr, 32'h0000_1000);
        chk("stall/data_held", wr_data, 8'h11);
        wr_ready = 1'b1;
        exp_q = '{{32'h0000_1000, 8'h11}};
        check_frame("stall", 0, 1, 0, 32'd0);

        // Inter-byte timeout after the third byte, then recovery.
        clear_mon();
        fq = '{8'hA5, 8'h01, 8'h00};
        send_fq(0);
        chk("timeout/busy_mid", busy, 1'b1);
        for (int i = 0; i < 40 && err_cyc < 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("timeout/err_delay", err_cyc - last_dv_cyc, 16);
        check_frame("timeout", 0, 1, 0, 32'd0);
        clear_mon();
        fq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'hBA};
        exp_q = '{{32'h0000_1000, 8'h11}, {32'h0000_1001, 8'h22}};
        send_fq(0);
        check_frame("after_timeout", 1, 0, 0, 32'd0);

        // Stray bytes ignored, then unknown command rejected.
        clear_mon();
        fq = '{8'h00, 8'hFF};
        send_fq(1);
        chk("stray/busy", busy, 1'b0);
        fq = '{8'hA5, 8'h03};
        send_fq(1);
        check_frame("bad_cmd", 0, 1, 0, 32'd0);

        // Reset in the middle of the payload with a write pending.
        clear_mon();
        wr_ready = 1'b0;
        fq = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22};
        send_fq(1);
        chk("midrst/pending", wr_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst/outputs", {wr_valid, wr_addr, wr_data, jump_valid, jump_addr, frame_done, frame_err, busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_ready = 1'b1;
        check_frame("midrst", 0, 0, 0, 32'd0);

        // Randomized frames against the frame-level model.
        for (int t = 0; t < 24; t++) begin
            clear_mon();
            kind = $urandom_range(0, 9);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            if (kind == 0) begin
                cmd = 8'($urandom_range(3, 255));
                len = 0;
            end else if (kind <= 2) begin
                cmd = 8'h02;
                len = (kind == 2) ? $urandom_range(1, 3) : 0;
            end else begin
                cmd = 8'h01;
                len = $urandom_range(0, 6);
            end
            corrupt = ($urandom_range(0, 4) == 0);
            fq.delete();
            fq.push_back(8'hA5);
            fq.push_back(cmd);
            if (kind == 0) begin
                send_fq(3);
                check_frame("rand_badcmd", 0, 1, 0, 32'd0);
            end else begin
                fq.push_back(a[7:0]);   fq.push_back(a[15:8]);
                fq.push_back(a[23:16]); fq.push_back(a[31:24]);
                fq.push_back(8'(len));
                for (int k = 0; k < len; k++) begin
                    pb = 8'($urandom);
                    fq.push_back(pb);
                    if (cmd == 8'h01) exp_q.push_back({a + 32'(k), pb});
                end
                s = 0;
                for (int k = 1; k < fq.size(); k++) s += int'(fq[k]);
                ck = 8'((256 - (s % 256)) % 256);
                if (corrupt) ck = ck + 8'($urandom_range(1, 255));
                fq.push_back(ck);
                good = !corrupt && !(cmd == 8'h02 && len != 0);
                send_fq(3);
                check_frame("rand_frame", good ? 1 : 0, good ? 0 : 1,
                            (good && cmd == 8'h02) ? 1 : 0, a);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
